sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Arbitrates the single-port SRAM between two requesters: port 0 is the SPI interface, port 1 is the local host/test port.
- Sequences each SRAM access: address and data mux, write-enable pulse, access-time wait, read-data capture and completion ack.
- Sits between the SPI interface's SRAM-side signals (address, write enable, write data, read data) and the SRAM macro.

Parameters:
- ADDR_W, 8, SRAM address width.
- DATA_W, 8, SRAM data width.
- ACCESS_CYCLES, 2, SRAM access time in SCK cycles; legal values 1..15.

Ports:
- SCK input 1: system clock; all state updates on its rising edge.
- rst input 1: synchronous, active-high reset.
- req0, req1 input 1 each: access request, ports 0 and 1.
- we0, we1 input 1 each: 1 = write, 0 = read.
- addr0, addr1 input ADDR_W each: access address.
- wdata0, wdata1 input DATA_W each: write data.
- gnt0, gnt1 output 1 each: port owns the SRAM.
- ack0, ack1 output 1 each: one-cycle completion pulse.
- rdata output DATA_W: captured read data, shared by both ports.
- sram_addr output ADDR_W: SRAM address.
- sram_wdata output DATA_W: SRAM write data.
- sram_we output 1: SRAM write enable.
- sram_rdata input DATA_W: SRAM read data, valid ACCESS_CYCLES edges after the address is applied.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - gnt0, gnt1, ack0, ack1, sram_we all 0.
  - sram_addr, sram_wdata, rdata all 0.
  - Access counter 0; last_grant = 1, so port 0 wins the first tie.
  - Reset mid-access aborts immediately: no ack is issued and the write pulse is dropped.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - At each edge, pick a winner among the asserted req lines.
  - Single request: that port wins.
  - Both requests: the port not equal to last_grant wins (round-robin).
  - On a winner: register gnt_winner=1; sram_addr, sram_wdata and sram_we from the winner's inputs; last_grant=winner; counter=1; go to ACCESS.
  - No request: stay in IDLE with all outputs held.
- ACCESS:
  - sram_we is 1 only during the first ACCESS cycle, and only for writes; it is cleared at the next edge.
  - sram_addr and sram_wdata are held for the whole access.
  - At an edge with counter==ACCESS_CYCLES: rdata <= sram_rdata (reads only; rdata is unchanged on writes); ack_winner <= 1; go to DONE.
  - Otherwise counter increments.
- DONE: lasts one cycle. At the next edge, gnt and ack clear and the FSM returns to IDLE.
- Latency from the request-sampling edge E0:
  - gnt is visible after E0.
  - ack is high for exactly the cycle after edge E0+ACCESS_CYCLES.
  - The next grant occurs at E0+ACCESS_CYCLES+2 at the earliest.
  - Throughput is one access per ACCESS_CYCLES+2 cycles.
- Requester rules:
  - Hold req, we, addr and wdata stable from assertion until ack.
  - A req still high after ack is a new request.
  - Dropping req mid-access does not abort; the access completes and ack still pulses.
- Only one of gnt0/gnt1 is ever high; the same holds for ack0/ack1.
- In round-robin mode, a continuously requesting port waits at most one access of the other port.
- Inputs of the non-granted port are ignored.

Optional Feature:
- Macro SRAM_ARB_FIXED_PRIO_EN.
- Defined: port 0 wins every tie. last_grant is still maintained but not used, so port 1 can starve.
- Undefined: round-robin as described in Behaviour.

Decomposition:
- Package sram_arb_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - port index constants (PORT_SPI=0, PORT_HOST=1);
  - the counter width constant (4 bits).
- One natural sub-module: rr_pick2, a combinational 2-requester picker.
  - Inputs: req0, req1, last_grant.
  - Outputs: valid, winner.
  - Contains the SRAM_ARB_FIXED_PRIO_EN branch.

Test Plan (ACCESS_CYCLES=2):
1. Single write: after reset, req0=1, we0=1, addr0=0x3C, wdata0=0xA5.
   - gnt0 high from the next cycle.
   - sram_we high for exactly one cycle with sram_addr=0x3C and sram_wdata=0xA5.
   - ack0 is a single pulse 2 edges later.
2. Read-back: req1=1, we1=0, addr1=0x3C, with an SRAM model returning 0xA5.
   - rdata=0xA5 during ack1; sram_we stays 0 throughout.
3. Contention: req0 and req1 held high for 4 accesses.
   - Grant order is 0,1,0,1; gnt0 and gnt1 are never high together; each access spans 4 cycles.
   - Rerun with SRAM_ARB_FIXED_PRIO_EN defined: grant order is 0,0,0,0.
4. Early drop: req0 pulsed for one cycle only.
   - The access still completes and ack0 pulses once.
   - No second grant follows.
5. Reset mid-access: assert rst during the second ACCESS cycle.
   - The next cycle shows all outputs 0 and no ack.
   - After release, simultaneous requests grant port 0 first.
6. Back-to-back: req1 held high across its ack.
   - A second grant to port 1 occurs 1 cycle after DONE, with unchanged addr.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic PORT_SPI  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/sram_arbiter_rr_pick2.sv
// Combinational two-requester picker: round-robin on ties, or fixed port-0
// priority when SRAM_ARB_FIXED_PRIO_EN is defined.
module rr_pick2
    import sram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

`ifdef SRAM_ARB_FIXED_PRIO_EN
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant;
`endif

    // Winner selection for the current request pair.
    always_comb begin
        valid  = req0 | req1;
        winner = PORT_SPI;
        if (req0 && req1) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            winner = PORT_SPI;
`else
            winner = ~last_grant;
`endif
        end else if (req1) begin
            winner = PORT_HOST;
        end else begin
            winner = PORT_SPI;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter and access sequencer for the SPI port (0) and the
// host/test port (1). Define SRAM_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              SCK,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_t        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              last_grant_r;
    logic              owner_r;
    logic              is_write_r;

    logic              pick_valid_s;
    logic              pick_winner_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    rr_pick2 u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_r),
        .valid      (pick_valid_s),
        .winner     (pick_winner_s)
    );

    // Route the winning port's request fields toward the SRAM.
    always_comb begin
        if (pick_winner_s == PORT_HOST) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
    end

    // Access sequencer: grant, write pulse, access-time wait, capture, ack.
    always_ff @(posedge SCK) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            last_grant_r <= PORT_HOST;
            owner_r      <= PORT_SPI;
            is_write_r   <= 1'b0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            sram_we      <= 1'b0;
            sram_addr    <= {ADDR_W{1'b0}};
            sram_wdata   <= {DATA_W{1'b0}};
            rdata        <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        gnt0         <= (pick_winner_s == PORT_SPI);
                        gnt1         <= (pick_winner_s == PORT_HOST);
                        sram_addr    <= sel_addr_s;
                        sram_wdata   <= sel_wdata_s;
                        sram_we      <= sel_we_s;
                        is_write_r   <= sel_we_s;
                        owner_r      <= pick_winner_s;
                        last_grant_r <= pick_winner_s;
                        cnt_r        <= CNT_ONE;
                        state_r      <= ACCESS;
                    end
                end
                ACCESS: begin
                    sram_we <= 1'b0;
                    if (cnt_r == LAST_CNT) begin
                        if (!is_write_r) begin
                            rdata <= sram_rdata;
                        end
                        ack0    <= (owner_r == PORT_SPI);
                        ack1    <= (owner_r == PORT_HOST);
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    sram_we <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic, every cycle
// checked against a transaction-level timing model of the arbiter.
module tb_sram_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int AC     = 2;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              SCK = 1'b0;
    logic              rst;
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, ack0, ack1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_we;
    logic [DATA_W-1:0] sram_rdata;

    always #5 SCK = ~SCK;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(AC)) dut (
        .SCK(SCK), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata(rdata), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_we(sram_we), .sram_rdata(sram_rdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic       pre_we;
    logic [7:0] pre_addr, pre_wdata;

    // Model: an access occupies edges t=0 (grant) .. t=AC+1 (release).
    bit         m_busy;
    int         m_t;
    bit         m_own, m_wr, m_last;
    logic [7:0] e_addr, e_wdata, e_rdata;

    int  dut_log[$];
    int  dut_gcyc[$];
    bit  prev_g0, prev_g1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_busy = 1'b0; m_t = 0; m_last = 1'b1;
            e_addr = 8'h00; e_wdata = 8'h00; e_rdata = 8'h00;
        end else if (m_busy) begin
            m_t++;
            if (m_t == AC && !m_wr) e_rdata = ref_mem[e_addr];
            if (m_t == AC + 1) m_busy = 1'b0;
        end else if (req0 || req1) begin
            if (req0 && req1) m_own = FIXED ? 1'b0 : !m_last;
            else              m_own = req1;
            m_wr    = m_own ? we1 : we0;
            e_addr  = m_own ? addr1 : addr0;
            e_wdata = m_own ? wdata1 : wdata0;
            if (m_wr) ref_mem[e_addr] = e_wdata;
            m_last = m_own;
            m_busy = 1'b1;
            m_t    = 0;
        end
    endtask

    task automatic compare();
        chk("gnt0", gnt0, m_busy && !m_own);
        chk("gnt1", gnt1, m_busy && m_own);
        chk("ack0", ack0, m_busy && m_t == AC && !m_own);
        chk("ack1", ack1, m_busy && m_t == AC && m_own);
        chk("sram_we", sram_we, m_busy && m_t == 0 && m_wr);
        chk("sram_addr", sram_addr, e_addr);
        chk("sram_wdata", sram_wdata, e_wdata);
        chk("rdata", rdata, e_rdata);
        chk("gnt_exclusive", gnt0 & gnt1, 1'b0);
        chk("ack_exclusive", ack0 & ack1, 1'b0);
    endtask

    task automatic step();
        @(posedge SCK);
        @(negedge SCK);
        cyc++;
        if (pre_we) mem[pre_addr] = pre_wdata;
        model_edge();
        compare();
        pre_we = sram_we; pre_addr = sram_addr; pre_wdata = sram_wdata;
        sram_rdata = (m_busy && !m_wr && m_t >= AC - 1) ? mem[sram_addr] : ~mem[sram_addr];
        if (gnt0 && !prev_g0) begin dut_log.push_back(0); dut_gcyc.push_back(cyc); end
        if (gnt1 && !prev_g1) begin dut_log.push_back(1); dut_gcyc.push_back(cyc); end
        prev_g0 = gnt0; prev_g1 = gnt1;
    endtask

    task automatic drain();
        for (int g = 0; g < 12 && m_busy; g++) step();
        chk("drain_idle", m_busy, 1'b0);
    endtask

    initial begin
        int base, acks, exp_order[4];
        int st[2];
        bit rq[2], rw[2];
        logic [7:0] ra[2], rd[2];

        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        sram_rdata = 8'h00; pre_we = 1'b0; pre_addr = 8'h00; pre_wdata = 8'h00;
        prev_g0 = 1'b0; prev_g1 = 1'b0;
        m_busy = 1'b0; m_t = 0; m_own = 1'b0; m_wr = 1'b0; m_last = 1'b1;
        e_addr = 8'h00; e_wdata = 8'h00; e_rdata = 8'h00;

        step(); step();
        chk("reset_gnt0", gnt0, 1'b0);
        chk("reset_rdata", rdata, 8'h00);
        rst = 1'b0;
        step();

        // 1. single write
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h3C; wdata0 = 8'hA5;
        step();
        chk("t1_gnt0", gnt0, 1'b1);
        chk("t1_we", sram_we, 1'b1);
        chk("t1_addr", sram_addr, 8'h3C);
        chk("t1_wdata", sram_wdata, 8'hA5);
        step();
        chk("t1_we_cleared", sram_we, 1'b0);
        chk("t1_no_early_ack", ack0, 1'b0);
        step();
        chk("t1_ack0", ack0, 1'b1);
        req0 = 1'b0; we0 = 1'b0;
        step();
        chk("t1_ack0_single", ack0, 1'b0);
        chk("t1_gnt0_released", gnt0, 1'b0);

        // 2. read-back through port 1
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h3C;
        step();
        chk("t2_gnt1", gnt1, 1'b1);
        chk("t2_no_we", sram_we, 1'b0);
        step(); step();
        chk("t2_ack1", ack1, 1'b1);
        chk("t2_rdata", rdata, 8'hA5);
        req1 = 1'b0;
        drain();

        // 3. contention
        if (FIXED) exp_order = '{0, 0, 0, 0};
        else       exp_order = '{0, 1, 0, 1};
        base = dut_log.size();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h11; wdata0 = 8'h5C;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h22; wdata1 = 8'hC3;
        for (int g = 0; g < 40 && (dut_log.size() - base) < 4; g++) step();
        chk("t3_grants", dut_log.size() - base, 4);
        if (dut_log.size() - base >= 4) begin
            for (int i = 0; i < 4; i++) chk("t3_order", dut_log[base + i], exp_order[i]);
            for (int i = 1; i < 4; i++)
                chk("t3_spacing", dut_gcyc[base + i] - dut_gcyc[base + i - 1], AC + 2);
        end
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        drain();

        // 4. early drop
        base = dut_log.size(); acks = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
        step();
        req0 = 1'b0; addr0 = 8'hEE;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ack0) acks++;
        end
        chk("t4_ack_count", acks, 1);
        chk("t4_grant_count", dut_log.size() - base, 1);

        // 5. reset mid-access
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'h77;
        step(); step();
        rst = 1'b1;
        step();
        chk("t5_gnt0", gnt0, 1'b0);
        chk("t5_ack0", ack0, 1'b0);
        chk("t5_we", sram_we, 1'b0);
        chk("t5_addr", sram_addr, 8'h00);
        chk("t5_wdata", sram_wdata, 8'h00);
        rst = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10; we0 = 1'b0;
        step();
        chk("t5_tie_port0", gnt0, 1'b1);
        req0 = 1'b0; req1 = 1'b0;
        drain();

        // 6. back-to-back on port 1
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h3C;
        step();
        chk("t6_gnt1_first", gnt1, 1'b1);
        step(); step();
        chk("t6_ack1", ack1, 1'b1);
        step();
        chk("t6_gap", gnt1, 1'b0);
        step();
        chk("t6_gnt1_second", gnt1, 1'b1);
        chk("t6_addr", sram_addr, 8'h3C);
        req1 = 1'b0;
        drain();

        // random traffic
        st[0] = 0; st[1] = 0;
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0; rw[p] = 1'b0; ra[p] = 8'h00; rd[p] = 8'h00;
        end
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            for (int p = 0; p < 2; p++) begin
                if (rst || (m_busy && m_t == AC && m_own == p[0])) st[p] = 0;
                if (st[p] == 0) begin
                    if ($urandom_range(0, 2) == 0) begin
                        st[p] = 1; rq[p] = 1'b1; rw[p] = $urandom_range(0, 1) == 1;
                        ra[p] = 8'($urandom_range(0, 7)); rd[p] = 8'($urandom);
                    end else begin
                        rq[p] = 1'b0; rw[p] = $urandom_range(0, 1) == 1;
                        ra[p] = 8'($urandom); rd[p] = 8'($urandom);
                    end
                end else if (st[p] == 1 && m_busy && m_own == p[0] && $urandom_range(0, 7) == 0) begin
                    st[p] = 2; rq[p] = 1'b0; ra[p] = 8'($urandom); rd[p] = 8'($urandom);
                end else if (st[p] == 2) begin
                    ra[p] = 8'($urandom); rd[p] = 8'($urandom); rw[p] = $urandom_range(0, 1) == 1;
                end
            end
            req0 = rq[0]; we0 = rw[0]; addr0 = ra[0]; wdata0 = rd[0];
            req1 = rq[1]; we1 = rw[1]; addr1 = ra[1]; wdata1 = rd[1];
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
